// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side companion to the LFSR pattern generator. It samples a parallel
// word stream and brings a local LFSR predictor into step with it. Once locked
// it compares every valid word with the prediction. It reports per-word match
// and error pulses, a saturating error count, a pulse per full pattern period,
// and loss of lock.
//
// Parameters
//   NUM_BITS    word and LFSR width, 3..8
//   LOCK_COUNT  consecutive correct predictions needed to declare lock, 1..15
//   LOSS_COUNT  consecutive mismatches while locked that drop lock, 1..15
//
// Ports
//   i_Clk          clock, rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_Data_DV      i_Data is valid this cycle; invalid cycles hold all state
//   i_Data         received LFSR word
//   i_Clear_Count  synchronous clear of o_Err_Count (wins over an increment)
//   o_Locked       level, high while the checker is locked
//   o_Match        one-cycle pulse, checked word matched the prediction
//   o_Error        one-cycle pulse, checked word mismatched while locked
//   o_Period_Done  one-cycle pulse per 2^NUM_BITS-1 words checked while locked
//   o_Err_Count    mismatches counted while locked, saturates at 16'hFFFF
//
// Every output is registered. The word sampled at edge k shows up on the
// pulses and the count during cycle k+1.
// -----------------------------------------------------------------------------
module lfsr_checker #(
  parameter int NUM_BITS   = 4,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Data_DV,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Count,
  output logic                o_Locked,
  output logic                o_Match,
  output logic                o_Error,
  output logic                o_Period_Done,
  output logic [15:0]         o_Err_Count
);

  // ---------------------------------------------------------------------------
  // Polynomial
  // ---------------------------------------------------------------------------
  // The feedback bit is the XNOR of the tap bits. Each mask marks those taps
  // with 0-indexed bit positions, so the taps are the same as the generator's.
  function automatic logic [7:0] tap_mask(input int n);
    case (n)
      3:       return 8'h06;  // taps 3,2
      4:       return 8'h0C;  // taps 4,3
      5:       return 8'h14;  // taps 5,3
      6:       return 8'h30;  // taps 6,5
      7:       return 8'h60;  // taps 7,6
      8:       return 8'hB8;  // taps 8,6,5,4
      default: return 8'h0C;
    endcase
  endfunction

  localparam logic [7:0]          TAP_ALL = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS    = TAP_ALL[NUM_BITS-1:0];

  // With XNOR feedback the all-ones word maps onto itself. That is the lockup
  // state, and it can never be used as a seed.
  localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

  // A locked period holds 2^N-1 words. The counter wraps at 2^N-2, so the
  // pulse comes on the (2^N-1)-th word.
  localparam logic [NUM_BITS-1:0] PERIOD_WRAP = {{(NUM_BITS-1){1'b1}}, 1'b0};

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_COUNT);

  function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] w);
    return {w[NUM_BITS-2:0], ~^(w & TAPS)};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_VERIFY  = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [1:0]          state_q,      state_d;
  logic [NUM_BITS-1:0] pred_q,       pred_d;
  logic [3:0]          match_cnt_q,  match_cnt_d;
  logic [3:0]          miss_cnt_q,   miss_cnt_d;
  logic [NUM_BITS-1:0] period_cnt_q, period_cnt_d;

  logic                match_d;
  logic                error_d;
  logic                period_done_d;
  logic                err_inc;
  logic [15:0]         err_count_d;

  logic                word_hit;
  logic                word_is_ones;

  assign word_hit     = (i_Data == pred_q);
  assign word_is_ones = (i_Data == ALL_ONES);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pred_d        = pred_q;
    match_cnt_d   = match_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    period_cnt_d  = period_cnt_q;
    match_d       = 1'b0;
    error_d       = 1'b0;
    period_done_d = 1'b0;
    err_inc       = 1'b0;

    if (i_Data_DV) begin
      case (state_q)
        ST_ACQUIRE: begin
          if (!word_is_ones) begin
            pred_d      = lfsr_next(i_Data);
            match_cnt_d = 4'd0;
            state_d     = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (word_hit) begin
            pred_d      = lfsr_next(i_Data);
            match_cnt_d = match_cnt_q + 4'd1;
            match_d     = 1'b1;
            if (match_cnt_q + 4'd1 == LOCK_TGT) begin
              state_d      = ST_LOCKED;
              miss_cnt_d   = 4'd0;
              period_cnt_d = '0;
            end
          end else if (!word_is_ones) begin
            // Wrong prediction but a usable word: start over from this word.
            pred_d      = lfsr_next(i_Data);
            match_cnt_d = 4'd0;
          end else begin
            match_cnt_d = 4'd0;
            state_d     = ST_ACQUIRE;
          end
        end

        ST_LOCKED: begin
          // Flywheel: the predictor keeps its own sequence and ignores the
          // received word. A single corrupted word then costs one error and
          // does not knock the predictor out of step.
          pred_d = lfsr_next(pred_q);

          if (period_cnt_q == PERIOD_WRAP) begin
            period_cnt_d  = '0;
            period_done_d = 1'b1;
          end else begin
            period_cnt_d = period_cnt_q + 1'b1;
          end

          if (word_hit) begin
            match_d    = 1'b1;
            miss_cnt_d = 4'd0;
          end else begin
            error_d    = 1'b1;
            err_inc    = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_q + 4'd1 == LOSS_TGT) begin
              state_d = ST_ACQUIRE;
            end
          end
        end

        default: state_d = ST_ACQUIRE;
      endcase
    end
  end

  // The clear wins over a same-cycle increment. The count holds at all-ones.
  always_comb begin
    if (i_Clear_Count) begin
      err_count_d = 16'h0000;
    end else if (err_inc && (o_Err_Count != 16'hFFFF)) begin
      err_count_d = o_Err_Count + 16'd1;
    end else begin
      err_count_d = o_Err_Count;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated only with non-blocking assignments. Every register
  // then samples the pre-edge value of every other register, whatever order
  // the simulator runs the statements in.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= ST_ACQUIRE;
      pred_q        <= '0;
      match_cnt_q   <= 4'd0;
      miss_cnt_q    <= 4'd0;
      period_cnt_q  <= '0;
      o_Locked      <= 1'b0;
      o_Match       <= 1'b0;
      o_Error       <= 1'b0;
      o_Period_Done <= 1'b0;
      o_Err_Count   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pred_q        <= pred_d;
      match_cnt_q   <= match_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      period_cnt_q  <= period_cnt_d;
      o_Locked      <= (state_d == ST_LOCKED);
      o_Match       <= match_d;
      o_Error       <= error_d;
      o_Period_Done <= period_done_d;
      o_Err_Count   <= err_count_d;
    end
  end

endmodule
